cmd_receiver: RTL and testbench
===============================

Name: cmd_receiver

Overview:
- Receive end of the two-byte UART command link; the counterpart of the command transmitter.
- Deserialises 8N1 UART bytes on RX and pairs them as upper byte first, then lower byte.
- Presents the assembled 16-bit cmd with a sticky cmd_rdy flag to the downstream command processor.
- Contains its own UART receiver sub-module.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud).
- TIMEOUT_CYCLES, 1000000, max clk cycles allowed between end of upper byte and start of lower byte (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- RX  input  1  serial line, idle high, asynchronous to clk
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
- cmd  output  16  assembled command, {upper_byte, lower_byte}
- cmd_rdy  output  1  high while cmd holds a complete, unconsumed command

Behaviour:
- Reset values: cmd=16'h0000, cmd_rdy=0, pairing FSM in UPPER, UART receiver in IDLE.
- RX synchronisation: double-flop synchroniser, both flops reset to 1 so reset never produces a false start.

UART receiver states: IDLE, START, DATA, STOP.
- IDLE to START on a synchronised falling edge; the baud counter loads BAUD_DIV/2.
- START: at count expiry, re-sample. If the line is high (glitch), return to IDLE. Otherwise go to DATA and load BAUD_DIV.
- DATA: sample 8 bits LSB first, each at mid-bit, shifting right into rx_data.
- STOP: sample at mid stop bit.
  - Sample 1: rx_rdy is set on the following clock and the receiver returns to IDLE.
  - Sample 0 (framing error): the byte is discarded, rx_rdy is not set, and the receiver returns to IDLE.
- rx_rdy is a level. It is cleared by clr_rx_rdy or on the next detected start edge.

Pairing FSM states: UPPER, LOWER.
- UPPER, on rx_rdy:
  - upper_hold <= rx_data;
  - pulse clr_rx_rdy;
  - clear cmd_rdy (a new command has begun);
  - go to LOWER.
- LOWER, on rx_rdy:
  - cmd <= {upper_hold, rx_data};
  - set cmd_rdy;
  - pulse clr_rx_rdy;
  - go to UPPER.
- Latency: cmd and cmd_rdy update exactly 1 clk after rx_rdy rises for the lower byte.
- cmd holds its value until the next completed pair; it is never modified by the upper byte alone.
- cmd_rdy priority: set beats clr_cmd_rdy in the same cycle. clr_cmd_rdy while cmd_rdy=0 has no effect.
- A framing-errored byte is invisible to the FSM and does not advance pairing.
- Reset mid-frame: all state aborts immediately. A partially received byte or an unpaired upper byte is lost.

Optional Feature:
- Macro CMD_RX_TIMEOUT_EN.
- Defined:
  - In LOWER, a counter counts clk cycles while the UART receiver is IDLE.
  - On reaching TIMEOUT_CYCLES, the FSM returns to UPPER, discards upper_hold, and leaves cmd and cmd_rdy unchanged.
  - The counter clears on entry to LOWER and on any start edge.
- Not defined: no counter; LOWER waits indefinitely for the second byte.

Decomposition:
- Shared package (comm_pkg):
  - rx_state_t enum {IDLE, START, DATA, STOP};
  - pair_state_t enum {UPPER, LOWER};
  - default BAUD_DIV constant, shared with the transmitter side.
- Sub-module uart_rx:
  - ports clk, rst_n, RX, clr_rdy, rx_data[7:0], rdy;
  - holds the synchroniser, baud counter, bit counter and shift register.
- cmd_receiver instantiates uart_rx and holds the pairing FSM, upper_hold, cmd, cmd_rdy and the optional timeout.

Test Plan (BAUD_DIV=16 in simulation):
- Send bytes 0xA5 then 0x3C → cmd=16'hA53C and cmd_rdy=1 exactly 1 clk after the lower byte's rx_rdy; cmd_rdy=0 throughout the upper byte.
- With cmd_rdy=1 from 0xA53C, pulse clr_cmd_rdy → cmd_rdy=0, cmd stays 0xA53C. Then send 0x12, 0x34 back-to-back with zero idle → cmd=16'h1234, cmd_rdy=1.
- Assert clr_cmd_rdy in the same cycle cmd_rdy is set → cmd_rdy=1 (set wins).
- Send 0x5A with stop bit forced 0, then 0x80, 0x01 → no effect from 0x5A; cmd=16'h8001.
- 4-clk low glitch on idle RX → no byte received. Reset asserted mid-DATA of the lower byte, then 0xDE, 0xAD → cmd=16'hDEAD.
- CMD_RX_TIMEOUT_EN with TIMEOUT_CYCLES=500: send 0x11, idle 600 clks, then 0x22, 0x33 → cmd=16'h2233, no command containing 0x11.

Source files
------------

// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - types and constants shared by both ends of the UART command link
package comm_pkg;

  // 50 MHz system clock at 19200 baud
  localparam int DEFAULT_BAUD_DIV = 2604;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic {UPPER, LOWER} pair_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART byte receiver with level rdy; CMD_RX_TIMEOUT_EN adds the idle output
module uart_rx
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
`ifdef CMD_RX_TIMEOUT_EN
  ,
  output logic       idle
`endif
);

  localparam int CW = $clog2(BAUD_DIV + 1);

  rx_state_t     state, state_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift_nxt;
  logic          rdy_nxt;
  logic          fall, tick;

  assign fall = rx_prev & ~rx_sync;
  assign tick = (baud_cnt == CW'(1));

`ifdef CMD_RX_TIMEOUT_EN
  assign idle = (state == IDLE);
`endif

  // Synchroniser flops reset high so leaving reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      rx_data  <= shift_nxt;
      rdy      <= rdy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = (baud_cnt != '0) ? baud_cnt - CW'(1) : baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = rx_data;
    rdy_nxt      = rdy & ~clr_rdy;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_nxt    = START;
          baud_cnt_nxt = CW'(BAUD_DIV / 2);
          rdy_nxt      = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (rx_sync) begin
            state_nxt = IDLE;
          end else begin
            state_nxt    = DATA;
            baud_cnt_nxt = CW'(BAUD_DIV);
            bit_cnt_nxt  = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt    = {rx_sync, rx_data[7:1]};
          baud_cnt_nxt = CW'(BAUD_DIV);
          bit_cnt_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          // A low stop bit is a framing error: the byte is dropped silently
          if (rx_sync) rdy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/cmd_receiver.sv
// rtl/cmd_receiver.sv - pairs UART bytes into 16-bit commands; CMD_RX_TIMEOUT_EN bounds the wait for the lower byte
module cmd_receiver
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
`ifdef CMD_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy
);

  logic [7:0]  rx_data;
  logic        rx_rdy, clr_rx_rdy;
  pair_state_t state, state_nxt;
  logic [7:0]  upper_hold, upper_hold_nxt;
  logic [15:0] cmd_nxt;
  logic        cmd_rdy_nxt;
  logic        timed_out;

`ifdef CMD_RX_TIMEOUT_EN
  logic rx_idle;
`endif

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .clr_rdy(clr_rx_rdy),
    .rx_data(rx_data),
    .rdy    (rx_rdy)
`ifdef CMD_RX_TIMEOUT_EN
    ,
    .idle   (rx_idle)
`endif
  );

`ifdef CMD_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Held at zero outside LOWER and whenever a frame is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != LOWER || !rx_idle) begin
      to_cnt <= '0;
    end else if (!timed_out) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign timed_out = (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UPPER;
      upper_hold <= '0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      state      <= state_nxt;
      upper_hold <= upper_hold_nxt;
      cmd        <= cmd_nxt;
      cmd_rdy    <= cmd_rdy_nxt;
    end
  end

  // Completing a pair overrides a simultaneous consumer acknowledge
  always_comb begin
    state_nxt      = state;
    upper_hold_nxt = upper_hold;
    cmd_nxt        = cmd;
    cmd_rdy_nxt    = cmd_rdy & ~clr_cmd_rdy;
    clr_rx_rdy     = 1'b0;
    unique case (state)
      UPPER: begin
        if (rx_rdy) begin
          upper_hold_nxt = rx_data;
          cmd_rdy_nxt    = 1'b0;
          clr_rx_rdy     = 1'b1;
          state_nxt      = LOWER;
        end
      end
      LOWER: begin
        if (rx_rdy) begin
          cmd_nxt     = {upper_hold, rx_data};
          cmd_rdy_nxt = 1'b1;
          clr_rx_rdy  = 1'b1;
          state_nxt   = UPPER;
        end else if (timed_out) begin
          upper_hold_nxt = '0;
          state_nxt      = UPPER;
        end
      end
      default: state_nxt = UPPER;
    endcase
  end

endmodule

// File: tb/tb_cmd_receiver.sv
// tb/tb_cmd_receiver.sv - directed bench for cmd_receiver with a queue-based pairing model
module tb_cmd_receiver;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;

  always #5 clk = ~clk;

  cmd_receiver #(
    .BAUD_DIV(BAUD)
`ifdef CMD_RX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(500)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: every good byte sent is queued; each completed reception takes the next one
  logic [7:0]  sent[$];
  int          rd_idx = 0;
  logic        have_upper = 1'b0;
  logic [7:0]  exp_upper = '0;
  logic [15:0] exp_cmd = '0;
  logic        exp_rdy = 1'b0;
  logic        rdy_q = 1'b0;
  logic        overrun = 1'b0;
  logic        drop_upper = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx     <= sent.size();
      have_upper <= 1'b0;
      exp_cmd    <= '0;
      exp_rdy    <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= dut.rx_rdy;
      if (dut.rx_rdy && !rdy_q) begin
        if (rd_idx >= sent.size()) overrun <= 1'b1;
        rd_idx <= rd_idx + 1;
        if (!have_upper) begin
          exp_upper  <= sent[rd_idx];
          have_upper <= 1'b1;
          exp_rdy    <= 1'b0;
        end else begin
          exp_cmd    <= {exp_upper, sent[rd_idx]};
          exp_rdy    <= 1'b1;
          have_upper <= 1'b0;
        end
      end else begin
        if (clr_cmd_rdy) exp_rdy <= 1'b0;
        if (drop_upper) have_upper <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (cmd !== exp_cmd || cmd_rdy !== exp_rdy) begin
      miscompares++;
      $display("FAIL cycle_compare t=%0t: cmd=%h cmd_rdy=%b, expected cmd=%h cmd_rdy=%b",
               $time, cmd, cmd_rdy, exp_cmd, exp_rdy);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      RX = f[i];
      repeat (BAUD - 1) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    sent.push_back(b);
    send_frame(b, 1'b1, 10);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_cmd", {16'h0, cmd}, 32'h0);
    check("reset_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Basic pair
    send_byte(8'hA5);
    check("upper_only_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    send_byte(8'h3C);
    idle(4);
    check("pair_a53c_cmd", {16'h0, cmd}, 32'hA53C);
    check("pair_a53c_rdy", {31'h0, cmd_rdy}, 32'h1);

    // Acknowledge, then acknowledge again while already clear
    pulse_clr();
    check("clr_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("clr_keeps_cmd", {16'h0, cmd}, 32'hA53C);
    pulse_clr();
    check("clr_when_clear", {31'h0, cmd_rdy}, 32'h0);

    // Back-to-back frames with no idle between them
    send_byte(8'h12);
    send_byte(8'h34);
    idle(4);
    check("pair_1234_cmd", {16'h0, cmd}, 32'h1234);
    check("pair_1234_rdy", {31'h0, cmd_rdy}, 32'h1);

    // Acknowledge lands on the same edge the pair completes
    send_byte(8'hC3);
    fork
      send_byte(8'h96);
      begin : watch_rdy
        int n;
        n = 0;
        while (!dut.rx_rdy && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("setwins_rx_rdy_seen", {31'h0, dut.rx_rdy}, 32'h1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("setwins_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
        check("setwins_cmd", {16'h0, cmd}, 32'hC396);
      end
    join
    idle(4);

    // Framing error is invisible to pairing
    send_frame(8'h5A, 1'b0, 10);
    idle(2 * BAUD);
    check("framing_cmd_held", {16'h0, cmd}, 32'hC396);
    send_byte(8'h80);
    send_byte(8'h01);
    idle(4);
    check("after_framing_cmd", {16'h0, cmd}, 32'h8001);
    check("after_framing_rdy", {31'h0, cmd_rdy}, 32'h1);

    // Short low glitch on an idle line
    @(negedge clk);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    idle(3 * BAUD);
    check("glitch_no_byte", {31'h0, overrun}, 32'h0);
    check("glitch_cmd_held", {16'h0, cmd}, 32'h8001);

    // Reset in the middle of the lower byte's data bits
    send_byte(8'h77);
    sent.push_back(8'h55);
    send_frame(8'h55, 1'b1, 5);
    @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_reset_cmd", {16'h0, cmd}, 32'h0);
    check("midframe_reset_rdy", {31'h0, cmd_rdy}, 32'h0);
    rst_n = 1'b1;
    idle(2 * BAUD);
    send_byte(8'hDE);
    send_byte(8'hAD);
    idle(4);
    check("after_reset_cmd", {16'h0, cmd}, 32'hDEAD);
    check("after_reset_rdy", {31'h0, cmd_rdy}, 32'h1);

`ifdef CMD_RX_TIMEOUT_EN
    send_byte(8'h11);
    idle(600);
    drop_upper = 1'b1;
    @(negedge clk);
    drop_upper = 1'b0;
    check("timeout_cmd_held", {16'h0, cmd}, 32'hDEAD);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(4);
    check("timeout_cmd", {16'h0, cmd}, 32'h2233);
    check("timeout_rdy", {31'h0, cmd_rdy}, 32'h1);
`endif

    check("all_bytes_consumed", rd_idx, sent.size());
    check("no_extra_bytes", {31'h0, overrun}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
